// File: rtl/fpu_pkg.sv
// Shared widths and the load-pipe entry type for the FPU load path.
package fpu_pkg;

   localparam int FPU_DATA_W = 32;
   localparam int FPU_DEST_W = 3;

   typedef struct packed {
      logic                  valid;
      logic [FPU_DEST_W-1:0] dest;
      logic [FPU_DATA_W-1:0] data;
   } load_entry_t;

endpackage

// File: rtl/load_stage.sv
// One elastic pipeline stage: a valid bit plus a {data, dest} payload register.
module load_stage #(
   parameter int DATA_W = 32,
   parameter int DEST_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              up_valid,
   input  logic [DATA_W-1:0] up_data,
   input  logic [DEST_W-1:0] up_dest,
   input  logic              dn_ready,
   output logic              dn_valid,
   output logic [DATA_W-1:0] dn_data,
   output logic [DEST_W-1:0] dn_dest
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [DEST_W-1:0] dest_q;
   logic              load_en;

   // The stage can take a new entry when it is empty or its entry moves on.
   assign load_en = !valid_q || dn_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         dest_q  <= '0;
      end else if (clr) begin
         valid_q <= 1'b0;
      end else if (load_en) begin
         valid_q <= up_valid;
         if (up_valid) begin
            data_q <= up_data;
            dest_q <= up_dest;
         end
      end
   end

   assign dn_valid = valid_q;
   assign dn_data  = data_q;
   assign dn_dest  = dest_q;

endmodule

// File: rtl/load_pipe.sv
// Elastic DEPTH-stage load pipe with flush and in-flight count.
// Define LOAD_PIPE_HAZARD_EN to build the per-destination busy_mask scoreboard.
module load_pipe
   import fpu_pkg::*;
#(
   parameter int DATA_W = FPU_DATA_W,
   parameter int DEST_W = FPU_DEST_W,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [DEST_W-1:0]          in_dest,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [DEST_W-1:0]          out_dest,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [2**DEST_W-1:0]       busy_mask
);

   localparam int CNT_W = $clog2(DEPTH+1);

   // Handshake: a transfer happens on a port exactly in a cycle where valid
   // and ready are both high at the rising edge; valid never waits on ready,
   // and in_ready may depend combinationally on out_ready.

   logic [DEPTH-1:0]  stage_v;
   logic [DATA_W-1:0] stage_d [DEPTH];
   logic [DEST_W-1:0] stage_t [DEPTH];
   logic [CNT_W-1:0]  count_q;
   logic              in_xfer;
   logic              out_xfer;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic              up_v;
      logic [DATA_W-1:0] up_d;
      logic [DEST_W-1:0] up_t;
      logic              dn_rdy;

      if (i == 0) begin : g_head
         assign up_v = in_valid;
         assign up_d = in_data;
         assign up_t = in_dest;
      end else begin : g_body
         assign up_v = stage_v[i-1];
         assign up_d = stage_d[i-1];
         assign up_t = stage_t[i-1];
      end

      // Downstream is blocked only when every later stage is full and the tail stalls.
      if (i == DEPTH-1) begin : g_tail
         assign dn_rdy = out_ready;
      end else begin : g_mid
         assign dn_rdy = out_ready || !(&stage_v[DEPTH-1:i+1]);
      end

      load_stage #(
         .DATA_W (DATA_W),
         .DEST_W (DEST_W)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .clr      (flush),
         .up_valid (up_v),
         .up_data  (up_d),
         .up_dest  (up_t),
         .dn_ready (dn_rdy),
         .dn_valid (stage_v[i]),
         .dn_data  (stage_d[i]),
         .dn_dest  (stage_t[i])
      );
   end

   assign in_ready  = !rst && !flush && (out_ready || !(&stage_v));
   assign out_valid = stage_v[DEPTH-1];
   assign out_data  = out_valid ? stage_d[DEPTH-1] : '0;
   assign out_dest  = out_valid ? stage_t[DEPTH-1] : '0;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
      end
   end

   assign count = count_q;

`ifdef LOAD_PIPE_HAZARD_EN
   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (stage_v[i]) begin
            busy_mask[stage_t[i]] = 1'b1;
         end
      end
   end
`else
   assign busy_mask = '0;
`endif

endmodule

// File: tb/tb_load_pipe.sv
// Directed and randomized bench for load_pipe (DEPTH=2, DATA_W=32, DEST_W=3).
module tb_load_pipe;
   import fpu_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [2:0]  in_dest;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_dest;
   logic [1:0]  count;
   logic [7:0]  busy_mask;

   load_pipe #(.DATA_W(32), .DEST_W(3), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dest   (in_dest),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_dest  (out_dest),
      .count     (count),
      .busy_mask (busy_mask)
   );

   always #5 clk = ~clk;

`ifdef LOAD_PIPE_HAZARD_EN
   localparam logic [7:0] HZ_35 = 8'h28;
`else
   localparam logic [7:0] HZ_35 = 8'h00;
`endif

   // Reference model: each in-flight entry carries the earliest cycle it may
   // be presented at the tail; exp_q keeps accepted data in order.
   typedef struct {
      load_entry_t e;
      int          arr;
   } mdl_t;

   mdl_t        mq[$];
   logic [31:0] exp_q[$];
   int          cyc;
   int          checks;
   int          passes;
   int          peak;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic step(input logic iv, input logic [31:0] d, input logic [2:0] ds,
                       input logic ordy, input logic fl, input logic rs);
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_od;
      logic [2:0]  e_ot;
      logic [7:0]  e_bm;
      mdl_t        m;
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      in_dest   = ds;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      #1;
      e_ir = !rs && !fl && ((mq.size() < DEPTH) || ordy);
      e_ov = (mq.size() > 0) && (mq[0].arr <= cyc);
      e_od = e_ov ? mq[0].e.data : 32'h0;
      e_ot = e_ov ? mq[0].e.dest : 3'h0;
      e_bm = 8'h00;
`ifdef LOAD_PIPE_HAZARD_EN
      foreach (mq[k]) e_bm[mq[k].e.dest] = 1'b1;
`endif
      chk("in_ready", {31'b0, in_ready}, {31'b0, e_ir});
      chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
      chk("out_data", out_data, e_od);
      chk("out_dest", {29'b0, out_dest}, {29'b0, e_ot});
      chk("count", {30'b0, count}, mq.size());
      chk("busy_mask", {24'b0, busy_mask}, {24'b0, e_bm});
      if (count > peak) peak = count;
      if (out_valid && ordy) begin
         chk("sb_avail", {31'b0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) chk("sb_order", out_data, exp_q.pop_front());
      end
      if (rs || fl) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(d);
      if (rs) begin
         mq.delete();
      end else begin
         if (e_ov && ordy) begin
            void'(mq.pop_front());
            if (mq.size() > 0 && mq[0].arr < cyc + 1) mq[0].arr = cyc + 1;
         end
         if (fl) begin
            mq.delete();
         end else if (iv && e_ir) begin
            m.e   = '{valid: 1'b1, dest: ds, data: d};
            m.arr = cyc + DEPTH;
            mq.push_back(m);
         end
      end
      cyc++;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      peak   = 0;
      cyc    = 0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0;
      flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);

      // Reset held, then released: in_ready low under reset, reset outputs after.
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

      // Stream two entries with out_ready high.
      peak = 0;
      step(1'b1, 32'hDEADBEEF, 3'd3, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h3F800000, 3'd5, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("stream_c2_data", out_data, 32'hDEADBEEF);
      chk("stream_hazard", {24'b0, busy_mask}, {24'b0, HZ_35});
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("stream_c3_data", out_data, 32'h3F800000);
      chk("stream_c3_dest", {29'b0, out_dest}, 32'd5);
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("stream_peak", peak, 32'd2);
      chk("hazard_clear", {24'b0, busy_mask}, 32'h0);

      // Backpressure, then simultaneous in/out while full.
      step(1'b1, 32'hDEADBEEF, 3'd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h12345678, 3'd2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hCAFEF00D, 3'd4, 1'b0, 1'b0, 1'b0);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_count", {30'b0, count}, 32'd2);
      step(1'b1, 32'hCAFEF00D, 3'd4, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hCAFEF00D, 3'd4, 1'b0, 1'b0, 1'b0);
      chk("bp_hold_data", out_data, 32'hDEADBEEF);
      step(1'b1, 32'hCAFEF00D, 3'd4, 1'b1, 1'b0, 1'b0);
      chk("full_xfer_ready", {31'b0, in_ready}, 32'd1);
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("full_xfer_count", {30'b0, count}, 32'd2);
      chk("drain_second", out_data, 32'h12345678);
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("full_xfer_new", out_data, 32'hCAFEF00D);
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);

      // Randomized traffic with occasional flush.
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), 1'b0);
      end
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);

      // Flush with two entries in flight and a concurrent request.
      step(1'b1, 32'h11111111, 3'd6, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h22222222, 3'd7, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h33333333, 3'd0, 1'b0, 1'b1, 1'b0);
      chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("flush_count", {30'b0, count}, 32'd0);
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_out_data", out_data, 32'd0);
      repeat (3) step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);

      // Reset while full and stalled.
      step(1'b1, 32'h44444444, 3'd3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h55555555, 3'd5, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h66666666, 3'd1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_mid_count", {30'b0, count}, 32'd0);
      chk("rst_mid_busy", {24'b0, busy_mask}, 32'd0);
      step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
